cp0: RTL and testbench
======================

// Module: cp0
// PURPOSE
// - MIPS-style coprocessor-0 register file and exception/interrupt controller.
// - Sits directly downstream of the system bridge: consumes its hwirq[7:2] vector
//   (timer0, timer1, test_interrupt, 3 spare lines) and its peers' exception reports.
// - Decides when the pipeline must trap, records EPC/Cause, and serves mfc0/mtc0/eret.
// PARAMETERS
// - PRID      32'h0000_3000  constant value returned for register 15 (PRId)
// - INT_CODE  5'd0           ExcCode recorded when an interrupt is taken
// PORTS
// - clk          in   1   system clock, all state updates on rising edge
// - rst          in   1   asynchronous, active-high reset
// - reg_addr     in   5   CP0 register number for mfc0 read / mtc0 write
// - write_enable in   1   mtc0 write strobe this cycle
// - write_data   in   32  mtc0 data
// - read_result  out  32  mfc0 data, combinational from reg_addr and current state
// - hwirq        in   6   bit i = hardware interrupt line i+2, level-sensitive
// - exc_valid    in   1   synchronous exception reported by pipeline this cycle
// - exc_code     in   5   ExcCode of that exception
// - exc_bd       in   1   faulting instruction is in a branch delay slot
// - exc_pc       in   32  PC of faulting/interrupted instruction (word aligned)
// - eret         in   1   eret retiring this cycle
// - trap         out  1   take exception/interrupt this cycle (redirect to handler)
// - epc          out  32  current EPC register (eret target)
// - exl          out  1   current SR.EXL
// BEHAVIOUR
// - Registers: SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]};
//   Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0};
//   EPC(14) = 32 bits, bits[1:0] always 0; PRId(15) = PRID. Other numbers read 0.
// - Reset (async): IM=0, EXL=0, IE=0, IP=0, BD=0, ExcCode=0, EPC=0.
//   Outputs after reset: trap=0, epc=0, exl=0, read_result=0 except reg 15.
// - IP sampling: each edge, IP <= hwirq. 1-cycle latency: hwirq high before edge N
//   gives IP set and irq pending from edge N.
// - int_pend = IE & ~EXL & |(IP & IM).
// - trap = int_pend | (exc_valid & ~EXL). Combinational.
// - Exception is ignored while EXL=1; no nesting.
// - Two-state control (EXL=0 NORMAL, EXL=1 HANDLER).
// - NORMAL -> HANDLER on a trap cycle. At the edge:
//   - EXL <= 1 and BD <= exc_bd.
//   - EPC <= exc_bd ? exc_pc-4 : exc_pc, with bits[1:0] forced 0.
//   - ExcCode <= int_pend ? INT_CODE : exc_code. Interrupt beats exc_valid.
// - HANDLER -> NORMAL on eret: EXL <= 0 at the edge. EPC, Cause unchanged.
// - mtc0 writes:
//   - SR: only IM, EXL, IE are writable.
//   - EPC: write_data & ~3.
//   - Cause and PRId: read-only, writes ignored.
//   - Writes take effect at the edge; read_result shows the old value that cycle.
// - Same-cycle priority, highest first: trap > eret > mtc0.
//   - trap with mtc0 to SR/EPC: the trap's EXL/EPC values win; a write to IM/IE still lands.
//   - eret with mtc0 SR: the write lands, then EXL is forced 0.
// - IP keeps tracking hwirq in every state, including HANDLER.
// - Clearing a line is a device action, not a CP0 action.
// - Reset mid-handler returns to NORMAL immediately (async), with IM=0 so no trap.
// TESTING
// - Post-reset: read 12/13/14 -> 0, read 15 -> 32'h0000_3000, trap=0 with hwirq=6'h3F.
// - mtc0 SR=32'h0000_0401, hwirq[0]=1: trap=1 one edge after hwirq rises.
//   After the trap edge: exl=1, ExcCode=0, EPC=exc_pc.
// - exc_valid, exc_code=5'd4, exc_bd=1, exc_pc=32'h0000_3008: trap=1.
//   After the edge: EPC=32'h0000_3004, Cause=32'h8000_0010.
//   A second exc_valid while EXL=1 gives trap=0 and EPC unchanged.
// - Same cycle interrupt pending and exc_valid(code 10): ExcCode=0 (interrupt wins).
//   Then eret: exl=0 next edge; trap re-asserts while the line stays high.
// - mtc0 EPC=32'h0000_4007 -> read 14 = 32'h0000_4004.
//   mtc0 Cause=32'hFFFF_FFFF -> Cause unchanged.
// - Assert rst mid-handler (EXL=1, EPC=32'h3000): exl=0, epc=0 immediately, before any clock edge.

Source files
------------

// File: rtl/cp0_if.sv
// Pipeline-to-CP0 bus: mfc0/mtc0 access, interrupt lines, exception reports and trap outputs.
interface cp0_if;
  logic [4:0]  reg_addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic [5:0]  hwirq;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_pc;
  logic        eret;
  logic        trap;
  logic [31:0] epc;
  logic        exl;

  modport slave (
    input  reg_addr, write_enable, write_data, hwirq,
           exc_valid, exc_code, exc_bd, exc_pc, eret,
    output read_result, trap, epc, exl
  );

  modport master (
    output reg_addr, write_enable, write_data, hwirq,
           exc_valid, exc_code, exc_bd, exc_pc, eret,
    input  read_result, trap, epc, exl
  );
endinterface

// File: rtl/cp0.sv
// MIPS-style CP0: SR/Cause/EPC/PRId register file plus exception/interrupt trap control.
// SR.EXL doubles as the two-state control (NORMAL/HANDLER).
module cp0 #(
  parameter logic [31:0] PRID     = 32'h0000_3000,
  parameter logic [4:0]  INT_CODE = 5'd0
) (
  input  logic clk,
  input  logic rst,
  cp0_if.slave bus
);
  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] HANDLER = 1'b1;

  localparam logic [4:0] R_SR    = 5'd12;
  localparam logic [4:0] R_CAUSE = 5'd13;
  localparam logic [4:0] R_EPC   = 5'd14;
  localparam logic [4:0] R_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic [0:0]  exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_q, ip_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        trap;
  logic [31:0] sr_val, cause_val, exc_epc;

  assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

  assign int_pend = ie_q & (exl_q == NORMAL) & (|(ip_q & im_q));
  assign trap     = int_pend | (bus.exc_valid & (exl_q == NORMAL));
  assign exc_epc  = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;

  assign bus.trap = trap;
  assign bus.epc  = epc_q;
  assign bus.exl  = exl_q[0];

  always_comb begin
    bus.read_result = 32'b0;
    case (bus.reg_addr)
      R_SR:    bus.read_result = sr_val;
      R_CAUSE: bus.read_result = cause_val;
      R_EPC:   bus.read_result = epc_q;
      R_PRID:  bus.read_result = PRID;
      default: bus.read_result = 32'b0;
    endcase
  end

  // Later assignments override earlier ones: trap > eret > mtc0.
  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    ip_d      = bus.hwirq;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    if (bus.write_enable) begin
      if (bus.reg_addr == R_SR) begin
        im_d  = bus.write_data[15:10];
        exl_d = bus.write_data[1];
        ie_d  = bus.write_data[0];
      end
      if (bus.reg_addr == R_EPC)
        epc_d = {bus.write_data[31:2], 2'b00};
    end
    if (bus.eret)
      exl_d = NORMAL;
    if (trap) begin
      exl_d     = HANDLER;
      bd_d      = bus.exc_bd;
      epc_d     = {exc_epc[31:2], 2'b00};
      exccode_d = int_pend ? INT_CODE : bus.exc_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q      <= '0;
      exl_q     <= NORMAL;
      ie_q      <= 1'b0;
      ip_q      <= '0;
      bd_q      <= 1'b0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      ip_q      <= ip_d;
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end
endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: expectations queued at stimulus time, popped when outputs are sampled.
module tb_cp0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cp0_if bus();

  cp0 #(.PRID(32'h0000_3000), .INT_CODE(5'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic exp_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h with no expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    #1;
    d = bus.read_result;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] d;

  initial begin
    bus.reg_addr     = 5'd0;
    bus.write_enable = 1'b0;
    bus.write_data   = 32'h0;
    bus.hwirq        = 6'h3F;
    bus.exc_valid    = 1'b0;
    bus.exc_code     = 5'd0;
    bus.exc_bd       = 1'b0;
    bus.exc_pc       = 32'h0;
    bus.eret         = 1'b0;

    // Reset values, read while reset is held
    #1;
    exp_push("rst_sr", 32'h0);        rd(5'd12, d); pop_cmp(d);
    exp_push("rst_cause", 32'h0);     rd(5'd13, d); pop_cmp(d);
    exp_push("rst_epc", 32'h0);       rd(5'd14, d); pop_cmp(d);
    exp_push("rst_prid", 32'h3000);   rd(5'd15, d); pop_cmp(d);
    exp_push("rst_other", 32'h0);     rd(5'd3, d);  pop_cmp(d);
    step();
    rst = 1'b0;
    step(); step();
    exp_push("post_rst_trap", 32'h0); pop_cmp({31'b0, bus.trap});
    exp_push("post_rst_exl", 32'h0);  pop_cmp({31'b0, bus.exl});

    // mtc0 SR: old value visible during the write cycle
    bus.hwirq = 6'h00;
    bus.write_enable = 1'b1; bus.write_data = 32'h0000_0401;
    exp_push("sr_old_during_wr", 32'h0); rd(5'd12, d); pop_cmp(d);
    step();
    bus.write_enable = 1'b0;
    exp_push("sr_after_wr", 32'h0000_0401); rd(5'd12, d); pop_cmp(d);

    // Interrupt: 1-cycle sampling latency
    bus.hwirq = 6'h01; bus.exc_pc = 32'h0000_1000;
    #1;
    exp_push("irq_trap_before_edge", 32'h0); pop_cmp({31'b0, bus.trap});
    step();
    exp_push("irq_trap", 32'h1); pop_cmp({31'b0, bus.trap});
    step();
    exp_push("irq_exl", 32'h1);        pop_cmp({31'b0, bus.exl});
    exp_push("irq_epc", 32'h1000);     pop_cmp(bus.epc);
    exp_push("irq_cause", 32'h400);    rd(5'd13, d); pop_cmp(d);
    exp_push("irq_trap_masked", 32'h0); pop_cmp({31'b0, bus.trap});

    // eret together with mtc0 SR setting EXL: write lands, EXL still cleared
    bus.hwirq = 6'h00; bus.eret = 1'b1;
    bus.write_enable = 1'b1; bus.reg_addr = 5'd12; bus.write_data = 32'h0000_0403;
    step();
    bus.eret = 1'b0; bus.write_enable = 1'b0;
    exp_push("eret_exl", 32'h0);          pop_cmp({31'b0, bus.exl});
    exp_push("eret_sr", 32'h0000_0401);   rd(5'd12, d); pop_cmp(d);

    // Synchronous exception in a delay slot
    bus.exc_valid = 1'b1; bus.exc_code = 5'd4; bus.exc_bd = 1'b1; bus.exc_pc = 32'h0000_3008;
    #1;
    exp_push("exc_trap", 32'h1); pop_cmp({31'b0, bus.trap});
    step();
    bus.exc_valid = 1'b0;
    exp_push("exc_epc", 32'h0000_3004);     pop_cmp(bus.epc);
    exp_push("exc_cause", 32'h8000_0010);   rd(5'd13, d); pop_cmp(d);
    exp_push("exc_exl", 32'h1);             pop_cmp({31'b0, bus.exl});

    // Cause is read-only
    bus.write_enable = 1'b1; bus.reg_addr = 5'd13; bus.write_data = 32'hFFFF_FFFF;
    step();
    bus.write_enable = 1'b0;
    exp_push("cause_ro", 32'h8000_0010); rd(5'd13, d); pop_cmp(d);

    // Second exception while EXL=1 is ignored
    bus.exc_valid = 1'b1; bus.exc_code = 5'd7; bus.exc_bd = 1'b0; bus.exc_pc = 32'h0000_5000;
    #1;
    exp_push("nested_trap", 32'h0); pop_cmp({31'b0, bus.trap});
    step();
    bus.exc_valid = 1'b0;
    exp_push("nested_epc", 32'h0000_3004);   pop_cmp(bus.epc);
    exp_push("nested_cause", 32'h8000_0010); rd(5'd13, d); pop_cmp(d);

    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;

    // Interrupt and exception same cycle: interrupt wins
    bus.hwirq = 6'h01;
    step();
    bus.exc_valid = 1'b1; bus.exc_code = 5'd10; bus.exc_bd = 1'b0; bus.exc_pc = 32'h0000_2000;
    #1;
    exp_push("both_trap", 32'h1); pop_cmp({31'b0, bus.trap});
    step();
    bus.exc_valid = 1'b0;
    exp_push("both_cause", 32'h0000_0400); rd(5'd13, d); pop_cmp(d);
    exp_push("both_epc", 32'h0000_2000);   pop_cmp(bus.epc);

    // eret with line still high: trap re-asserts
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
    exp_push("reeret_exl", 32'h0);  pop_cmp({31'b0, bus.exl});
    exp_push("reeret_trap", 32'h1); pop_cmp({31'b0, bus.trap});
    bus.hwirq = 6'h00; bus.exc_pc = 32'h0000_3000;
    step();
    exp_push("retrap_exl", 32'h1);        pop_cmp({31'b0, bus.exl});
    exp_push("retrap_epc", 32'h0000_3000); pop_cmp(bus.epc);

    // EPC write drops low bits
    bus.write_enable = 1'b1; bus.reg_addr = 5'd14; bus.write_data = 32'h0000_4007;
    step();
    exp_push("epc_wr", 32'h0000_4004); rd(5'd14, d); pop_cmp(d);
    bus.write_data = 32'h0000_3000;
    step();
    bus.write_enable = 1'b0;
    exp_push("epc_restore", 32'h0000_3000); pop_cmp(bus.epc);

    // Asynchronous reset mid-handler, checked before any clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_push("async_rst_exl", 32'h0);  pop_cmp({31'b0, bus.exl});
    exp_push("async_rst_epc", 32'h0);  pop_cmp(bus.epc);
    exp_push("async_rst_trap", 32'h0); pop_cmp({31'b0, bus.trap});

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
